// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: port ids, the in-flight
// tag carried alongside each SRAM command, and the aging-counter width.
package sram_arb_pkg;

    localparam logic PORT_DISP = 1'b0;
    localparam logic PORT_UPD  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic is_read;
    } tag_t;

    function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundles the two requester ports and the SRAM command/data lines.
// The arbiter takes the slave view; requesters and the SRAM take the master view.
interface sram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_ready;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ready;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, sram_rdata,
        output p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, sram_rdata,
        input  p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_arb_tag_pipe.sv
// Two-deep shift register of read/write tags, aligned so stage 2 coincides
// with SRAM read data; flush clears both stages.
module sram_arb_tag_pipe
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic flush_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t s1_q;
    tag_t s2_q;

    always_ff @(posedge clk) begin
        if (flush_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= tag_i;
            s2_q <= s1_q;
        end
    end

    assign tag_o = s2_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between a high-priority display read port and
// an update read/write port, with aging so the update port cannot starve.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 4
) (
    input logic           clk,
    input logic           reset,
    sram_arbiter_if.slave bus
);

    localparam int unsigned     CntW    = wait_cnt_width(MAX_WAIT);
    localparam logic [CntW-1:0] MaxWait = CntW'(MAX_WAIT);

    logic [CntW-1:0]       wait_q, wait_d;
    logic                  gnt0, gnt1;
    logic                  en_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    tag_t                  tag_in, tag_out;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        wait_d = wait_q;
        if (!reset) begin
            if (bus.p1_req && wait_q == MaxWait) begin
                gnt1 = 1'b1;
            end else if (bus.p0_req) begin
                gnt0 = 1'b1;
            end else if (bus.p1_req) begin
                gnt1 = 1'b1;
            end
        end
        if (!bus.p1_req || gnt1) begin
            wait_d = '0;
        end else if (wait_q != MaxWait) begin
            wait_d = wait_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q  <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wait_q <= wait_d;
            en_q   <= gnt0 | gnt1;
            we_q   <= gnt1 & bus.p1_we;
            // Address and write data hold across idle cycles.
            if (gnt0) begin
                addr_q  <= bus.p0_addr;
                wdata_q <= '0;
            end else if (gnt1) begin
                addr_q  <= bus.p1_addr;
                wdata_q <= bus.p1_wdata;
            end
        end
    end

    always_comb begin
        tag_in         = '0;
        tag_in.valid   = gnt0 | gnt1;
        tag_in.port    = gnt1 ? PORT_UPD : PORT_DISP;
        tag_in.is_read = gnt0 | (gnt1 & ~bus.p1_we);
    end

    sram_arb_tag_pipe u_tag_pipe (
        .clk     (clk),
        .flush_i (reset),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    assign bus.p0_ready   = gnt0;
    assign bus.p1_ready   = gnt1;
    assign bus.p0_rvalid  = !reset && tag_out.valid && tag_out.is_read && tag_out.port == PORT_DISP;
    assign bus.p1_rvalid  = !reset && tag_out.valid && tag_out.is_read && tag_out.port == PORT_UPD;
    assign bus.p0_rdata   = bus.sram_rdata;
    assign bus.p1_rdata   = bus.sram_rdata;
    assign bus.sram_en    = en_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed plus randomized bench for sram_arbiter against a transaction-level
// model: grants from the priority/aging rule, reads answered from a model memory.
module tb_sram_arbiter;
    localparam int unsigned MaxWait = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    sram_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .MAX_WAIT   (MaxWait)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Behavioural SRAM: 1-cycle registered read, preloaded contents.
    bit [7:0] mem [65536];
    bit       mem_wr [65536];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) begin
                mem[bus.sram_addr]    <= bus.sram_wdata;
                mem_wr[bus.sram_addr] <= 1'b1;
            end else begin
                bus.sram_rdata <= mem_wr[bus.sram_addr] ? mem[bus.sram_addr]
                                                         : init_val(bus.sram_addr);
            end
        end
    end

    // Reference model state.
    typedef struct {
        int       due;
        bit       port;
        bit [7:0] data;
    } resp_t;
    resp_t    pend[$];
    bit [7:0] ref_mem [65536];
    bit       ref_wr [65536];
    int       waited;
    int       cyc;
    int       last_g;
    logic        exp_en, exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic r0, input logic [15:0] a0,
                        input logic r1, input logic w1, input logic [15:0] a1,
                        input logic [7:0] d1);
        int       g;
        bit       ev0, ev1;
        bit [7:0] ed;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.p0_req   = r0;
        bus.p0_addr  = a0;
        bus.p1_req   = r1;
        bus.p1_we    = w1;
        bus.p1_addr  = a1;
        bus.p1_wdata = d1;
        #1;
        cyc++;
        g = -1;
        if (!rst) begin
            if (r1 && waited >= int'(MaxWait)) g = 1;
            else if (r0) g = 0;
            else if (r1) g = 1;
        end
        check("p0_ready", bus.p0_ready, g == 0);
        check("p1_ready", bus.p1_ready, g == 1);
        check("sram_en", bus.sram_en, exp_en);
        check("sram_we", bus.sram_we, exp_we);
        check("sram_addr", bus.sram_addr, exp_addr);
        check("sram_wdata", bus.sram_wdata, exp_wdata);
        ev0 = 0; ev1 = 0; ed = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (!rst) begin
                ev0 = (pend[0].port == 1'b0);
                ev1 = (pend[0].port == 1'b1);
                ed  = pend[0].data;
            end
            void'(pend.pop_front());
        end
        check("p0_rvalid", bus.p0_rvalid, ev0);
        check("p1_rvalid", bus.p1_rvalid, ev1);
        if (ev0) check("p0_rdata", bus.p0_rdata, ed);
        if (ev1) check("p1_rdata", bus.p1_rdata, ed);

        if (rst) begin
            pend.delete();
            waited    = 0;
            exp_en    = 0;
            exp_we    = 0;
            exp_addr  = 0;
            exp_wdata = 0;
        end else begin
            waited = (!r1 || g == 1) ? 0 : ((waited + 1 > int'(MaxWait)) ? int'(MaxWait) : waited + 1);
            exp_en = (g >= 0);
            exp_we = (g == 1) && w1;
            if (g == 0) begin
                exp_addr  = a0;
                exp_wdata = 0;
                pend.push_back('{due: cyc + 2, port: 1'b0,
                                 data: ref_wr[a0] ? ref_mem[a0] : init_val(a0)});
            end else if (g == 1) begin
                exp_addr  = a1;
                exp_wdata = d1;
                if (w1) begin
                    ref_mem[a1] = d1;
                    ref_wr[a1]  = 1'b1;
                end else begin
                    pend.push_back('{due: cyc + 2, port: 1'b1,
                                     data: ref_wr[a1] ? ref_mem[a1] : init_val(a1)});
                end
            end
        end
        last_g = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, 16'h0, 8'h0);
    endtask

    logic        r0, r1, w1;
    logic [15:0] a0, a1;
    logic [7:0]  d1;

    initial begin
        checks = 0; failures = 0; cyc = 0; waited = 0; last_g = -1;
        exp_en = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
        reset = 1'b1;
        bus.p0_req = 1; bus.p0_addr = 16'h0001;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 16'h0002; bus.p1_wdata = 0;
        @(posedge clk);

        // Reset held with both ports requesting; first grant goes to p0.
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0001, 1, 0, 16'h0002, 8'h0);
        step(0, 1, 16'h0001, 1, 0, 16'h0002, 8'h0);
        idle(4);

        // Single display read of a preloaded word.
        step(0, 1, 16'h0010, 0, 0, 16'h0, 8'h0);
        idle(3);

        // Update-port write followed by read of the same address.
        step(0, 0, 16'h0, 1, 1, 16'h1234, 8'h3C);
        step(0, 0, 16'h0, 1, 0, 16'h1234, 8'h0);
        idle(3);

        // Continuous contention: aging lets p1 in every MaxWait+1 cycles.
        for (int i = 0; i < 20; i++) step(0, 1, 16'h0100 + 16'(i), 1, 0, 16'h0200, 8'h0);
        idle(3);

        // Random traffic with gaps; requesters hold until accepted.
        r0 = 0; r1 = 0; w1 = 0; a0 = 0; a1 = 0; d1 = 0;
        for (int i = 0; i < 120; i++) begin
            if (!r0 || last_g == 0) begin
                r0 = ($urandom_range(0, 2) == 0);
                a0 = 16'h1230 | 16'($urandom_range(0, 15));
            end
            if (!r1 || last_g == 1) begin
                r1 = ($urandom_range(0, 1) == 0);
                w1 = ($urandom_range(0, 2) == 0);
                a1 = 16'h1230 | 16'($urandom_range(0, 15));
                d1 = 8'($urandom);
            end
            step(0, r0, a0, r1, w1, a1, d1);
        end
        idle(3);

        // Reset one cycle after a read is accepted: the read must vanish.
        step(0, 1, 16'h0010, 0, 0, 16'h0, 8'h0);
        step(1, 0, 16'h0, 0, 0, 16'h0, 8'h0);
        idle(3);
        // Aging counter restarts from zero after reset.
        for (int i = 0; i < 12; i++) step(0, 1, 16'h0300, 1, 0, 16'h0400, 8'h0);
        idle(3);

        check("pending_drained", pend.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-port, initialized block SRAM between the display fetch path (port 0, read-only, high priority) and the animation update path (port 1, read/write). It sits between the VGA pixel fetch logic and the animation engine on one side and the `sram` instance on the other. It registers the SRAM command, tracks in-flight reads, and routes read data back to the issuing port. An aging counter guarantees port 1 forward progress.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 16, SRAM address width
- MAX_WAIT, 4, consecutive denied cycles before port 1 overrides port 0 (≥1)
- clk  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  display read request
- p0_addr  in  ADDR_WIDTH  display read address
- p0_ready  out  1  p0 request accepted this cycle (combinational)
- p0_rvalid  out  1  p0 read data valid
- p0_rdata  out  DATA_WIDTH  p0 read data
- p1_req  in  1  update request
- p1_we  in  1  1 = write, 0 = read
- p1_addr  in  ADDR_WIDTH  update address
- p1_wdata  in  DATA_WIDTH  write data
- p1_ready  out  1  p1 request accepted this cycle (combinational)
- p1_rvalid  out  1  p1 read data valid (reads only)
- p1_rdata  out  DATA_WIDTH  p1 read data
- sram_en, sram_we  out  1  registered SRAM enable / write enable
- sram_addr  out  ADDR_WIDTH  registered SRAM address
- sram_wdata  out  DATA_WIDTH  registered SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM data_o (1-cycle registered read)

## Operation
- A request transfers in cycle N when req && ready. At most one port is granted per cycle.
- Grant rule: if p1_req && wait_cnt == MAX_WAIT, grant p1. Else if p0_req, grant p0. Else if p1_req, grant p1. Else grant none.
- wait_cnt, width clog2(MAX_WAIT+1):
  - Cleared on reset, on a p1 grant, or when p1_req is low.
  - Incremented, saturating at MAX_WAIT, when p1_req is high and p1 is not granted.
- On a grant, the command registers load {en=1, we, addr, wdata}. Port 0 loads we=0 and wdata=0. With no grant, sram_en=0 and sram_we=0; addr and wdata hold their previous values.
- Tag pipeline: a 2-stage shift register of {valid, port, is_read}, loaded at grant.
  - Stage-2 valid && is_read asserts the matching rvalid.
  - Writes complete silently; no rvalid is produced for them.
- p0_rdata and p1_rdata both pass sram_rdata through. Only the rvalid flags are steered.
- Requesters hold addr, we and wdata stable while req is high and ready is low.
- Reset:
  - All outputs go to 0 (ready low, rvalid low, sram_en/we low, sram_addr/wdata 0).
  - wait_cnt goes to 0 and the tag pipeline is flushed.
  - A reset mid-operation discards in-flight reads: no rvalid after reset deasserts.
  - ready is forced low while reset is high.

## Timing
- Grant and acceptance happen in cycle N. sram_* is driven in N+1. The SRAM samples at the end of N+1 and data_o is valid in N+2. rvalid is high in N+2 with the data.
- Read latency is exactly 2 cycles from acceptance. Throughput is 1 access per cycle, back-to-back, with no bubbles.
- A write accepted in N followed by a read of the same address accepted in N+1 returns the new data in N+3.
- Under continuous p0 and p1 requests, p1 is granted once every MAX_WAIT+1 cycles (p0 gets MAX_WAIT of every MAX_WAIT+1 cycles).

## Structure
- Package sram_arb_pkg holds:
  - localparams PORT_DISP=0 and PORT_UPD=1;
  - the tag struct {valid, port, is_read};
  - the wait-counter width function.
- One sub-module, sram_arb_tag_pipe: a 2-deep tag shift register with synchronous flush. The grant logic, counter and command registers stay in the top module.

## Test plan
- Reset: hold reset 3 cycles with both ports requesting → all outputs 0 and no ready during reset. First grant goes to p0 on the cycle after release.
- Single read: p0 reads 0x0010 with the SRAM preloaded to 0xA5 → p0_ready in N, sram_en/addr=0x0010 in N+1, p0_rvalid=1 and p0_rdata=0xA5 in N+2, exactly one pulse.
- Write then read: p1 writes 0x3C to 0x1234, then p1 reads 0x1234 → no rvalid for the write; p1_rvalid with 0x3C two cycles after the read is accepted; p0_rvalid stays 0.
- Starvation: p0 and p1 read continuously for 20 cycles, MAX_WAIT=4 → p1 is granted on cycles 5, 10, 15 and 20; p0 on all others; rvalid ordering matches grant order.
- Idle gaps: alternate p0 and p1 reads to distinct addresses with random gaps → every accepted read yields exactly one rvalid on the correct port with the correct data, and sram_en=0 in idle cycles.
- Reset mid-flight: accept a p0 read in N and assert reset in N+1 → no p0_rvalid in N+2 and wait_cnt is 0 afterward.
